// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: holds per-domain active-low resets after power-up
// or a software request, then releases them in a staggered order and records the cause.
module reset_sequencer #(
  parameter int unsigned Channels      = 2,
  parameter int unsigned Cycles        = 50_000_000,
  parameter int unsigned SoftCycles    = 1024,
  parameter int unsigned StaggerCycles = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                power,
  input  logic                sw_req,
  output logic [Channels-1:0] rst_n_out,
  output logic                ready,
  output logic [1:0]          cause
);

  localparam int unsigned MaxHs = (Cycles > SoftCycles) ? Cycles : SoftCycles;
  localparam int unsigned MaxAll = (MaxHs > StaggerCycles) ? MaxHs : StaggerCycles;
  localparam int unsigned CW = $clog2(MaxAll + 1);
  localparam int unsigned IW = (Channels > 1) ? $clog2(Channels) : 1;

  localparam logic [CW-1:0] HoldLoad    = CW'(Cycles - 1);
  localparam logic [CW-1:0] SoftLoad    = CW'(SoftCycles - 1);
  localparam logic [CW-1:0] StaggerLoad = CW'((StaggerCycles == 0) ? 0 : StaggerCycles - 1);
  localparam logic [IW-1:0] LastIdx     = IW'(Channels - 1);

  localparam logic [1:0] CausePor   = 2'd0;
  localparam logic [1:0] CausePower = 2'd1;
  localparam logic [1:0] CauseSoft  = 2'd2;

  typedef enum logic [1:0] {
    S_OFF,
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [Channels-1:0]  rst_n_q, rst_n_d;
  logic                 ready_q, ready_d;
  logic [1:0]           cause_q, cause_d;

  logic power_s;
  assign power_s = sync2_q;

  // Next-state: power loss beats a software request; both re-assert every domain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sync1_d = power;
    sync2_d = sync1_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    cause_d = cause_q;

    if (state_q != S_OFF && !power_s) begin
      state_d = S_OFF;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
      cause_d = CausePower;
    end else if ((state_q == S_RELEASE || state_q == S_RUN) && sw_req) begin
      state_d = S_HOLD;
      cnt_d   = SoftLoad;
      idx_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
      cause_d = CauseSoft;
    end else begin
      case (state_q)
        S_OFF: begin
          if (power_s) begin
            state_d = S_HOLD;
            cnt_d   = HoldLoad;
            idx_d   = '0;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            rst_n_d[0] = 1'b1;
            if (Channels == 1 || StaggerCycles == 0) begin
              rst_n_d = '1;
              ready_d = 1'b1;
              state_d = S_RUN;
            end else begin
              idx_d   = IW'(1);
              cnt_d   = StaggerLoad;
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == '0) begin
            rst_n_d[idx_q] = 1'b1;
            if (idx_q == LastIdx) begin
              ready_d = 1'b1;
              state_d = S_RUN;
            end else begin
              idx_d = idx_q + IW'(1);
              cnt_d = StaggerLoad;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      cause_q <= CausePor;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  assign rst_n_out = rst_n_q;
  assign ready     = ready_q;
  assign cause     = cause_q;

endmodule
